// File: rtl/muon_buffer_ctrl_pkg.sv
// Shared sizing constants and FSM encoding for the muon buffer write sequencer.
package muon_buffer_ctrl_pkg;

    localparam int MUON_BUF_BITS   = 2;   // log2 of the number of pages
    localparam int MUON_SEGS_BITS  = 6;   // log2 of the number of segments per page
    localparam int MUON_SEG_BITS   = 4;   // log2 of the number of words per segment
    localparam int MUON_DATA_WIDTH = 32;
    localparam int LOST_CNT_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HEADER    = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_SWITCH    = 3'd3,
        ST_WAIT_FREE = 3'd4
    } muon_state_e;

endpackage

// File: rtl/muon_buffer_ctrl_if.sv
// Trigger/ADC/release inputs and BRAM write/status outputs of the muon buffer sequencer.
interface muon_buffer_ctrl_if
    import muon_buffer_ctrl_pkg::*;
#(
    parameter int BUF_BITS   = MUON_BUF_BITS,
    parameter int MUON_BITS  = MUON_SEGS_BITS,
    parameter int SEG_BITS   = MUON_SEG_BITS,
    parameter int DATA_WIDTH = MUON_DATA_WIDTH
);
    localparam int NUM_BUF = 2**BUF_BITS;
    localparam int ADDR_W  = BUF_BITS + MUON_BITS + SEG_BITS;

    logic                  ENABLE;
    logic                  TRIG;
    logic [DATA_WIDTH-1:0] ADC_WORD;
    logic [NUM_BUF-1:0]    BUF_RELEASE;
    logic                  WR_EN;
    logic [ADDR_W-1:0]     WR_ADDR;
    logic [DATA_WIDTH-1:0] WR_DATA;
    logic [NUM_BUF-1:0]    FULL_MASK;
    logic [BUF_BITS-1:0]   CUR_BUF;
    logic                  IRQ;
    logic                  BUSY;
    logic [LOST_CNT_W-1:0] LOST_CNT;

    // master is the sequencer, slave is the trigger/PS/BRAM side
    modport master (
        input  ENABLE, TRIG, ADC_WORD, BUF_RELEASE,
        output WR_EN, WR_ADDR, WR_DATA, FULL_MASK, CUR_BUF, IRQ, BUSY, LOST_CNT
    );

    modport slave (
        output ENABLE, TRIG, ADC_WORD, BUF_RELEASE,
        input  WR_EN, WR_ADDR, WR_DATA, FULL_MASK, CUR_BUF, IRQ, BUSY, LOST_CNT
    );

endinterface

// File: rtl/muon_buffer_ctrl_rr_pick.sv
// Round-robin first-free page finder: scans start+1, start+2, ... wrapping back to start.
module muon_buf_rr_pick #(
    parameter int BUF_BITS = 2
) (
    input  logic [2**BUF_BITS-1:0] mask_i,
    input  logic [BUF_BITS-1:0]    start_i,
    output logic                   found_o,
    output logic [BUF_BITS-1:0]    idx_o
);
    localparam int NUM_BUF = 2**BUF_BITS;

    logic [BUF_BITS-1:0] cand;

    // scan farthest-first so the nearest free page is the last one written
    always_comb begin
        found_o = 1'b0;
        idx_o   = start_i;
        cand    = start_i;
        for (int off = NUM_BUF; off >= 1; off--) begin
            cand = start_i + BUF_BITS'(off);
            if (!mask_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/muon_buffer_ctrl.sv
// Muon buffer write sequencer: writes one timestamped segment per accepted trigger
// into a rotating set of BRAM pages and tracks page hand-off to the PS.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | armed, waiting for TRIG with ENABLE
//   HEADER    | timestamp word on the write port
//   CAPTURE   | ADC words 1..SEG_LEN-1 on the write port
//   SWITCH    | page just filled, looking for the next free page
//   WAIT_FREE | every page full, waiting for a PS release
module muon_buffer_ctrl
    import muon_buffer_ctrl_pkg::*;
#(
    parameter int BUF_BITS   = MUON_BUF_BITS,
    parameter int MUON_BITS  = MUON_SEGS_BITS,
    parameter int SEG_BITS   = MUON_SEG_BITS,
    parameter int DATA_WIDTH = MUON_DATA_WIDTH
) (
    input logic                CLK120,
    input logic                RESETN,
    muon_buffer_ctrl_if.master bus
);
    localparam int NUM_BUF = 2**BUF_BITS;
    localparam int ADDR_W  = BUF_BITS + MUON_BITS + SEG_BITS;

    muon_state_e           state_q, state_d;
    logic [31:0]           ts_q;
    logic [MUON_BITS-1:0]  seg_q, seg_d;
    logic [SEG_BITS-1:0]   word_q, word_d;
    logic [BUF_BITS-1:0]   cur_q, cur_d;
    logic [NUM_BUF-1:0]    full_q, full_d, full_set;
    logic [LOST_CNT_W-1:0] lost_q, lost_d;
    logic                  wr_en_q, wr_en_d;
    logic                  irq_q, irq_d;
    logic                  busy_q, busy_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  seg_last_done;
    logic                  pick_found;
    logic [BUF_BITS-1:0]   pick_idx;

    assign seg_last_done = (state_q == ST_CAPTURE) && (&word_q) && (&seg_q);

    always_comb begin
        full_set = '0;
        if (seg_last_done) full_set[cur_q] = 1'b1;
    end

    // releases only clear registered flags; a same-cycle set overrides a release
    assign full_d = (full_q & ~bus.BUF_RELEASE) | full_set;

    muon_buf_rr_pick #(.BUF_BITS(BUF_BITS)) u_pick (
        .mask_i  (full_d),
        .start_i (cur_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        seg_d     = seg_q;
        word_d    = word_q;
        cur_d     = cur_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        irq_d     = 1'b0;
        lost_d    = lost_q;
        if (bus.TRIG && (state_q != ST_IDLE) && !(&lost_q)) lost_d = lost_q + LOST_CNT_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (bus.TRIG && bus.ENABLE) begin
                    state_d   = ST_HEADER;
                    wr_en_d   = 1'b1;
                    wr_addr_d = {cur_q, seg_q, {SEG_BITS{1'b0}}};
                    wr_data_d = DATA_WIDTH'(ts_q);
                end
            end
            ST_HEADER: begin
                state_d   = ST_CAPTURE;
                word_d    = SEG_BITS'(1);
                wr_en_d   = 1'b1;
                wr_addr_d = {cur_q, seg_q, SEG_BITS'(1)};
                wr_data_d = bus.ADC_WORD;
            end
            ST_CAPTURE: begin
                if (!(&word_q)) begin
                    word_d    = word_q + SEG_BITS'(1);
                    wr_en_d   = 1'b1;
                    wr_addr_d = {cur_q, seg_q, word_q + SEG_BITS'(1)};
                    wr_data_d = bus.ADC_WORD;
                end else if (&seg_q) begin
                    seg_d   = '0;
                    irq_d   = 1'b1;
                    state_d = ST_SWITCH;
                end else begin
                    seg_d   = seg_q + MUON_BITS'(1);
                    state_d = ST_IDLE;
                end
            end
            ST_SWITCH, ST_WAIT_FREE: begin
                if (pick_found) begin
                    cur_d   = pick_idx;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_FREE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK120 or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= ST_IDLE;
            ts_q      <= '0;
            seg_q     <= '0;
            word_q    <= '0;
            cur_q     <= '0;
            full_q    <= '0;
            lost_q    <= '0;
            wr_en_q   <= 1'b0;
            irq_q     <= 1'b0;
            busy_q    <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ts_q      <= ts_q + 32'd1;
            seg_q     <= seg_d;
            word_q    <= word_d;
            cur_q     <= cur_d;
            full_q    <= full_d;
            lost_q    <= lost_d;
            wr_en_q   <= wr_en_d;
            irq_q     <= irq_d;
            busy_q    <= busy_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.WR_EN     = wr_en_q;
    assign bus.WR_ADDR   = wr_addr_q;
    assign bus.WR_DATA   = wr_data_q;
    assign bus.FULL_MASK = full_q;
    assign bus.CUR_BUF   = cur_q;
    assign bus.IRQ       = irq_q;
    assign bus.BUSY      = busy_q;
    assign bus.LOST_CNT  = lost_q;

endmodule

// File: tb/tb_muon_buffer_ctrl.sv
// Scoreboard bench for muon_buffer_ctrl: directed page-management scenarios followed
// by randomised triggers/releases, all checked against a cycle-level reference model.
module tb_muon_buffer_ctrl;

    typedef struct packed {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muon_buffer_ctrl_if bus ();

    muon_buffer_ctrl dut (
        .CLK120 (clk),
        .RESETN (rst_n),
        .bus    (bus)
    );

    int  n_chk   = 0;
    int  n_err   = 0;
    int  irq_cnt = 0;
    wr_t exp_q[$];
    int  irq_q[$];
    wr_t mon_e;

    // reference model: timestamp, write progress (0 = not writing, k = k-th write cycle),
    // pending page switch, waiting for a free page, segment/page, flags, lost count
    logic [31:0] m_ts;
    int          m_k, m_seg, m_cur, m_lost;
    bit          m_sw, m_wait;
    logic [3:0]  m_mask, m_new;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic logic [11:0] mk_addr(input int page, input int seg, input int word);
        return 12'(page * 1024 + seg * 16 + word);
    endfunction

    function automatic void model_clear();
        m_ts = 32'd0; m_k = 0; m_seg = 0; m_cur = 0; m_lost = 0;
        m_sw = 1'b0; m_wait = 1'b0; m_mask = 4'd0; m_new = 4'd0;
        exp_q.delete();
        irq_q.delete();
        irq_cnt = 0;
    endfunction

    task automatic step(input bit trig, input bit en, input logic [3:0] rel);
        logic [31:0] adc;
        logic [3:0]  mn, setb;
        bit          busy, sw_n, found;
        int          idx;
        wr_t         e;
        adc = $urandom;
        bus.TRIG        = trig;
        bus.ENABLE      = en;
        bus.ADC_WORD    = adc;
        bus.BUF_RELEASE = rel;

        busy = (m_k != 0) || m_sw || m_wait;
        if (trig && busy && m_lost < 65535) m_lost++;
        setb = 4'd0;
        sw_n = 1'b0;
        if (m_k != 0) begin
            if (m_k < 16) begin
                e.a = mk_addr(m_cur, m_seg, m_k);
                e.d = adc;
                exp_q.push_back(e);
            end
            if (m_k == 16) begin
                m_k = 0;
                if (m_seg == 63) begin
                    setb[m_cur] = 1'b1;
                    irq_q.push_back(m_cur);
                    m_seg = 0;
                    sw_n  = 1'b1;
                end else begin
                    m_seg++;
                end
            end else begin
                m_k++;
            end
        end else if (!busy && trig && en) begin
            e.a = mk_addr(m_cur, m_seg, 0);
            e.d = m_ts;
            exp_q.push_back(e);
            m_k = 1;
        end
        mn = (m_mask & ~rel) | setb;
        if (m_sw || m_wait) begin
            found = 1'b0;
            for (int off = 1; off <= 4; off++) begin
                idx = (m_cur + off) % 4;
                if (!found && !mn[idx]) begin
                    found = 1'b1;
                    m_cur = idx;
                end
            end
            m_wait = !found;
        end
        m_sw   = sw_n;
        m_mask = mn;
        m_new  = setb;
        m_ts   = m_ts + 32'd1;

        @(posedge clk);
        #1;
        chk("lost_cnt",  32'(bus.LOST_CNT),  32'(m_lost));
        chk("full_mask", 32'(bus.FULL_MASK), 32'(m_mask));
        chk("cur_buf",   32'(bus.CUR_BUF),   32'(m_cur));
        chk("busy",      32'(bus.BUSY),      32'((m_k != 0) || m_sw || m_wait));
    endtask

    // one accepted trigger and its full dead time, plus one cycle for a possible page switch
    task automatic seg_trig(input logic [3:0] rel_last, input int hdr);
        step(1'b1, 1'b1, 4'd0);
        if (hdr >= 0) chk("hdr_addr", 32'(bus.WR_ADDR), 32'(hdr));
        repeat (15) step(1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b1, rel_last);
        step(1'b0, 1'b1, 4'd0);
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.WR_EN) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL wr_unexpected: got write addr 0x%0h data 0x%0h, expected no write",
                             bus.WR_ADDR, bus.WR_DATA);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", 32'(bus.WR_ADDR), 32'(mon_e.a));
                    chk("wr_data", bus.WR_DATA, mon_e.d);
                end
            end
            if (bus.IRQ) begin
                irq_cnt++;
                if (irq_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL irq_unexpected: got IRQ=1 on page %0d, expected IRQ=0", bus.CUR_BUF);
                end else begin
                    chk("irq_page", 32'(bus.CUR_BUF), 32'(irq_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [3:0] r;
        bus.TRIG = 1'b0; bus.ENABLE = 1'b0; bus.ADC_WORD = 32'd0; bus.BUF_RELEASE = 4'd0;
        #2;
        chk("rst_wr_en",  32'(bus.WR_EN),     32'd0);
        chk("rst_busy",   32'(bus.BUSY),      32'd0);
        chk("rst_lost",   32'(bus.LOST_CNT),  32'd0);
        chk("rst_full",   32'(bus.FULL_MASK), 32'd0);
        hold_reset();

        // single capture at TS=100
        repeat (100) step(1'b0, 1'b1, 4'd0);
        step(1'b1, 1'b1, 4'd0);
        chk("t1_wr_en", 32'(bus.WR_EN),   32'd1);
        chk("t1_addr",  32'(bus.WR_ADDR), 32'h000);
        chk("t1_data",  bus.WR_DATA,      32'd100);
        repeat (15) step(1'b0, 1'b1, 4'd0);
        chk("t1_busy_116", 32'(bus.BUSY), 32'd1);
        step(1'b0, 1'b1, 4'd0);
        chk("t1_busy_117", 32'(bus.BUSY), 32'd0);

        // dead time, page rollover, all pages full
        hold_reset();
        repeat (3) step(1'b0, 1'b1, 4'd0);
        step(1'b1, 1'b1, 4'd0);
        repeat (4) step(1'b0, 1'b1, 4'd0);
        step(1'b1, 1'b1, 4'd0);
        repeat (11) step(1'b0, 1'b1, 4'd0);
        seg_trig(4'd0, 'h010);
        chk("dead_lost", 32'(bus.LOST_CNT), 32'd1);
        repeat (62) seg_trig(4'd0, -1);
        chk("roll_full", 32'(bus.FULL_MASK), 32'h1);
        chk("roll_cur",  32'(bus.CUR_BUF),   32'd1);
        chk("roll_irq",  32'(irq_cnt),       32'd1);
        seg_trig(4'd0, 'h400);
        repeat (191) seg_trig(4'd0, -1);
        chk("allfull_mask", 32'(bus.FULL_MASK), 32'hF);
        chk("allfull_busy", 32'(bus.BUSY),      32'd1);
        chk("allfull_irq",  32'(irq_cnt),       32'd4);
        repeat (3) step(1'b1, 1'b1, 4'd0);
        chk("allfull_lost", 32'(bus.LOST_CNT), 32'd4);
        step(1'b0, 1'b1, 4'b0100);
        chk("rel_cur", 32'(bus.CUR_BUF), 32'd2);
        seg_trig(4'd0, 'h800);

        // release corner cases
        step(1'b0, 1'b1, 4'b0100);
        chk("rel_filling", 32'(bus.FULL_MASK), 32'hB);
        repeat (62) seg_trig(4'd0, -1);
        seg_trig(4'b0100, -1);
        chk("rel_same_cycle", 32'(bus.FULL_MASK), 32'hF);
        step(1'b0, 1'b1, 4'b0011);
        chk("rel_multi_mask", 32'(bus.FULL_MASK), 32'hC);
        chk("rel_multi_cur",  32'(bus.CUR_BUF),   32'd0);
        step(1'b1, 1'b0, 4'd0);
        chk("dis_wr_en", 32'(bus.WR_EN),    32'd0);
        chk("dis_lost",  32'(bus.LOST_CNT), 32'd4);

        // asynchronous reset in the middle of a segment
        step(1'b1, 1'b1, 4'd0);
        repeat (4) step(1'b0, 1'b1, 4'd0);
        #3;
        chk("pre_rst_wr_en", 32'(bus.WR_EN), 32'd1);
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("arst_wr_en", 32'(bus.WR_EN),     32'd0);
        chk("arst_addr",  32'(bus.WR_ADDR),   32'd0);
        chk("arst_data",  bus.WR_DATA,        32'd0);
        chk("arst_busy",  32'(bus.BUSY),      32'd0);
        chk("arst_lost",  32'(bus.LOST_CNT),  32'd0);
        chk("arst_full",  32'(bus.FULL_MASK), 32'd0);
        chk("arst_cur",   32'(bus.CUR_BUF),   32'd0);
        chk("arst_irq",   32'(bus.IRQ),       32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 1'b1, 4'd0);
        chk("arst_hdr_addr", 32'(bus.WR_ADDR), 32'h000);
        chk("arst_hdr_data", bus.WR_DATA,      32'd0);

        // randomised traffic; a page is never released in the cycle right after it fills
        for (int i = 0; i < 4000; i++) begin
            r = 4'($urandom_range(15)) & ~m_new;
            if ($urandom_range(15) != 0) r = 4'd0;
            step(1'($urandom_range(3) == 0), 1'($urandom_range(7) != 0), r);
        end
        repeat (40) step(1'b0, 1'b0, 4'd0);
        chk("drain_writes", 32'(exp_q.size()), 32'd0);
        chk("drain_irqs",   32'(irq_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
